// File: rtl/risc_core_hs.sv
// Accumulator RISC core (HLT/SKZ/ADD/AND/XOR/LDA/STO/JMP) with a state-driven
// controller and a req/ack handshake to a shared instruction/data memory.
module risc_core_hs #(
    parameter int unsigned         DWIDTH = 8,
    parameter int unsigned         AWIDTH = 5,
    parameter int unsigned         CWIDTH = 16,
    parameter logic [AWIDTH-1:0]   RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halt,
    output logic [AWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] ac,
    output logic [CWIDTH-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MREAD,
        S_MWRITE,
        S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    state_t              state;
    logic [DWIDTH-1:0]   ir;
    opcode_t             opcode;
    logic [AWIDTH-1:0]   ir_addr;
    logic [CWIDTH-1:0]   cnt_next;

    assign opcode   = opcode_t'(ir[2:0]);
    assign ir_addr  = ir[AWIDTH+2:3];
    assign cnt_next = instr_cnt + CWIDTH'(1);

    // Upper instruction bits beyond the operand field carry no meaning.
    if (DWIDTH > AWIDTH + 3) begin : g_ir_hi
        logic unused_ir_hi;
        assign unused_ir_hi = ^ir[DWIDTH-1:AWIDTH+3];
    end

    // Bus controls are pure decodes of the state so they hold steady while waiting for ack.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            S_MREAD: begin
                mem_req  = 1'b1;
                mem_addr = ir_addr;
            end
            S_MWRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ir_addr;
            end
            default: ;
        endcase
    end

    assign mem_wdata = ac;
    assign halt      = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RST_PC;
            ac        <= '0;
            ir        <= '0;
            instr_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + AWIDTH'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_HLT: begin
                            instr_cnt <= cnt_next;
                            state     <= S_HALTED;
                        end
                        OP_SKZ: begin
                            if (ac == '0)
                                pc <= pc + AWIDTH'(1);
                            instr_cnt <= cnt_next;
                            state     <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc        <= ir_addr;
                            instr_cnt <= cnt_next;
                            state     <= S_FETCH;
                        end
                        OP_STO:  state <= S_MWRITE;
                        default: state <= S_MREAD;
                    endcase
                end
                S_MREAD: begin
                    if (mem_ack) begin
                        case (opcode)
                            OP_ADD:  ac <= ac + mem_rdata;
                            OP_AND:  ac <= ac & mem_rdata;
                            OP_XOR:  ac <= ac ^ mem_rdata;
                            OP_LDA:  ac <= mem_rdata;
                            default: ac <= ac;
                        endcase
                        instr_cnt <= cnt_next;
                        state     <= S_FETCH;
                    end
                end
                S_MWRITE: begin
                    if (mem_ack) begin
                        instr_cnt <= cnt_next;
                        state     <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (run)
                        state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_core_hs.sv
// Directed bench for risc_core_hs: small programs against a behavioural memory
// with a programmable number of ack wait cycles.
module tb_risc_core_hs;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 16;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                           XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          mem_req, mem_we, mem_ack, halt;
    logic [AW-1:0] mem_addr, pc;
    logic [DW-1:0] mem_wdata, mem_rdata, ac;
    logic [CW-1:0] instr_cnt;

    logic [DW-1:0] mem  [32];
    logic [DW-1:0] prog [32];
    logic          load = 1'b0;
    int            wait_n = 0;
    int            wcnt = 0;
    int            wr_cnt = 0;
    logic [AW-1:0] wr_addr = '0, held_addr = '0;
    logic [DW-1:0] wr_data = '0, held_wdata = '0;
    logic          held_we = 1'b0;
    logic          unstable = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    risc_core_hs #(
        .DWIDTH(DW),
        .AWIDTH(AW),
        .CWIDTH(CW),
        .RST_PC(5'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .halt(halt),
        .pc(pc),
        .ac(ac),
        .instr_cnt(instr_cnt)
    );

    assign mem_ack   = mem_req && (wcnt == wait_n);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (load) begin
            mem      <= prog;
            wr_cnt   <= 0;
            unstable <= 1'b0;
        end
        if (rst || !mem_req || mem_ack)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
        if (!rst && mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_addr       <= mem_addr;
            wr_data       <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        if (!rst && mem_req && wcnt != 0 &&
            (mem_addr != held_addr || mem_we != held_we || (mem_we && mem_wdata != held_wdata)))
            unstable <= 1'b1;
        if (mem_req) begin
            held_addr  <= mem_addr;
            held_we    <= mem_we;
            held_wdata <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ins(input logic [2:0] op, input logic [AW-1:0] a);
        return {a, op};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = '0;
    endtask

    // Reset the core and load prog into memory on the same edge.
    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_until_halt(input int max_cycles, output int cycles);
        cycles = 0;
        while (!halt && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
        end
        if (!halt) check("halt_timeout", 32'(cycles), 32'(max_cycles + 1));
    endtask

    int            cyc;
    logic          frozen_bad;
    logic [AW-1:0] pc0;
    logic [DW-1:0] ac0;
    logic [CW-1:0] cnt0;

    initial begin
        // Basic program, zero-wait memory
        clear_prog();
        prog[0]  = ins(LDA, 5'd10);
        prog[1]  = ins(ADD, 5'd11);
        prog[2]  = ins(STO, 5'd12);
        prog[3]  = ins(HLT, 5'd0);
        prog[10] = 8'h05;
        prog[11] = 8'h03;
        wait_n = 0;
        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ac", 32'(ac), 32'd0);
        check("rst_cnt", 32'(instr_cnt), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_req", 32'(mem_req), 32'd1);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        run_until_halt(200, cyc);
        check("p0_cycles", 32'(cyc), 32'd11);
        check("p0_wr_cnt", 32'(wr_cnt), 32'd1);
        check("p0_wr_addr", 32'(wr_addr), 32'd12);
        check("p0_wr_data", 32'(wr_data), 32'h08);
        check("p0_cnt", 32'(instr_cnt), 32'd4);
        check("p0_pc", 32'(pc), 32'd4);
        check("p0_ac", 32'(ac), 32'h08);

        // HALTED holds with run low, then a one-cycle run pulse resumes at pc
        pc0 = pc; ac0 = ac; cnt0 = instr_cnt;
        frozen_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req || !halt || pc != pc0 || ac != ac0 || instr_cnt != cnt0) frozen_bad = 1'b1;
        end
        check("halt_frozen", 32'(frozen_bad), 32'd0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("resume_halt", 32'(halt), 32'd0);
        check("resume_req", 32'(mem_req), 32'd1);
        check("resume_addr", 32'(mem_addr), 32'd4);
        run_until_halt(50, cyc);
        check("resume_cycles", 32'(cyc), 32'd2);
        check("resume_pc", 32'(pc), 32'd5);
        check("resume_cnt", 32'(instr_cnt), 32'd5);

        // Same program, 3 wait cycles on every access
        wait_n = 3;
        do_reset();
        run_until_halt(300, cyc);
        check("w3_cycles", 32'(cyc), 32'd32);
        check("w3_wr_cnt", 32'(wr_cnt), 32'd1);
        check("w3_wr_addr", 32'(wr_addr), 32'd12);
        check("w3_wr_data", 32'(wr_data), 32'h08);
        check("w3_cnt", 32'(instr_cnt), 32'd4);
        check("w3_pc", 32'(pc), 32'd4);
        check("w3_stable", 32'(unstable), 32'd0);
        wait_n = 0;

        // SKZ with ac == 0 skips
        clear_prog();
        prog[0] = ins(SKZ, 5'd0);
        do_reset();
        step(2);
        check("skz0_req", 32'(mem_req), 32'd1);
        check("skz0_addr", 32'(mem_addr), 32'd2);
        run_until_halt(50, cyc);
        check("skz0_pc", 32'(pc), 32'd3);
        check("skz0_cnt", 32'(instr_cnt), 32'd2);

        // SKZ with ac == 1 falls through
        clear_prog();
        prog[0]  = ins(LDA, 5'd20);
        prog[1]  = ins(SKZ, 5'd0);
        prog[20] = 8'h01;
        do_reset();
        step(5);
        check("skz1_req", 32'(mem_req), 32'd1);
        check("skz1_addr", 32'(mem_addr), 32'd2);
        run_until_halt(50, cyc);
        check("skz1_pc", 32'(pc), 32'd3);
        check("skz1_cnt", 32'(instr_cnt), 32'd3);

        // JMP to the top address and pc wrap on the following fetch
        clear_prog();
        prog[0]  = ins(LDA, 5'd20);
        prog[1]  = ins(JMP, 5'd5);
        prog[5]  = ins(JMP, 5'd31);
        prog[31] = ins(SKZ, 5'd0);
        prog[20] = 8'h01;
        do_reset();
        step(8);
        check("wrap_pc", 32'(pc), 32'd0);
        check("wrap_decode_req", 32'(mem_req), 32'd0);
        step(1);
        check("wrap_fetch_req", 32'(mem_req), 32'd1);
        check("wrap_fetch_addr", 32'(mem_addr), 32'd0);
        check("wrap_cnt", 32'(instr_cnt), 32'd4);

        // ADD overflow discards carry; AND/XOR follow
        clear_prog();
        prog[0]  = ins(LDA, 5'd20);
        prog[1]  = ins(ADD, 5'd21);
        prog[2]  = ins(HLT, 5'd0);
        prog[3]  = ins(XOR_, 5'd22);
        prog[4]  = ins(AND_, 5'd23);
        prog[20] = 8'hFF;
        prog[21] = 8'h02;
        prog[22] = 8'hA5;
        prog[23] = 8'h3C;
        do_reset();
        run_until_halt(50, cyc);
        check("add_ovf_ac", 32'(ac), 32'h01);
        check("add_ovf_cycles", 32'(cyc), 32'd8);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        run_until_halt(50, cyc);
        check("xor_and_ac", 32'(ac), 32'h24);
        check("xor_and_cnt", 32'(instr_cnt), 32'd6);

        // Reset during an MREAD wait cycle
        wait_n = 3;
        do_reset();
        step(15);
        check("mr_req", 32'(mem_req), 32'd1);
        check("mr_we", 32'(mem_we), 32'd0);
        check("mr_addr", 32'(mem_addr), 32'd21);
        check("mr_ac", 32'(ac), 32'hFF);
        check("mr_cnt", 32'(instr_cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_rst_pc", 32'(pc), 32'd0);
        check("mr_rst_ac", 32'(ac), 32'd0);
        check("mr_rst_cnt", 32'(instr_cnt), 32'd0);
        check("mr_rst_req", 32'(mem_req), 32'd1);
        check("mr_rst_addr", 32'(mem_addr), 32'd0);
        check("mr_rst_we", 32'(mem_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
